// File: rtl/alu32_seq.sv
// alu32_seq: command sequencer that initiates operations on an alu32.
// It accepts tagged requests and screens out illegal ones before they reach
// the ALU. It holds operands for a fixed latency, then returns the captured
// result, high word and NZVC flags over a valid/ready response port.
module alu32_seq #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    // command port
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [3:0]  cmd_tag,
    // ALU drive
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    // ALU observation
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_mul_hi,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        alu_c,
    // response port
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [31:0] rsp_hi,
    output logic [3:0]  rsp_flags,
    output logic [3:0]  rsp_tag,
    output logic        rsp_err,
    output logic [15:0] done_count
);

    // The counter counts down to zero, so LATENCY cycles of hold need LATENCY-1.
    localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

    localparam logic [3:0] OpDiv = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] done_q, done_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic [31:0] rsp_hi_q, rsp_hi_d;
    logic [3:0]  rsp_flags_q, rsp_flags_d;
    logic [3:0]  rsp_tag_q, rsp_tag_d;
    logic        rsp_err_q, rsp_err_d;

    logic        accept;
    logic        op_illegal;
    logic        div_zero;

    // Ready depends only on state, but is forced low for as long as reset is held.
    assign cmd_ready  = (state_q == IDLE) && !rst;
    assign accept     = cmd_valid && cmd_ready;
    assign op_illegal = (cmd_op[3:2] == 2'b11);
    assign div_zero   = (cmd_op == OpDiv) && (cmd_b == 32'd0);

    // Next-state logic: screen and launch commands, run the latency count, retire responses.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_result_d = rsp_result_q;
        rsp_hi_d     = rsp_hi_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rsp_tag_d = cmd_tag;
                    if (op_illegal) begin
                        rsp_result_d = 32'd0;
                        rsp_hi_d     = 32'd0;
                        rsp_flags_d  = 4'b0000;
                        rsp_err_d    = 1'b1;
                        state_d      = RESP;
                    end else if (div_zero) begin
                        rsp_result_d = 32'hFFFF_FFFF;
                        rsp_hi_d     = 32'd0;
                        rsp_flags_d  = 4'b0000;
                        rsp_err_d    = 1'b1;
                        state_d      = RESP;
                    end else begin
                        alu_a_d  = cmd_a;
                        alu_b_d  = cmd_b;
                        alu_op_d = cmd_op;
                        cnt_d    = CntLoad;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    rsp_result_d = alu_result;
                    rsp_hi_d     = alu_mul_hi;
                    rsp_flags_d  = {alu_n, alu_z, alu_v, alu_c};
                    rsp_err_d    = 1'b0;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    done_d  = done_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and drops any in-flight command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            done_q       <= 16'd0;
            alu_a_q      <= 32'd0;
            alu_b_q      <= 32'd0;
            alu_op_q     <= 4'd0;
            rsp_result_q <= 32'd0;
            rsp_hi_q     <= 32'd0;
            rsp_flags_q  <= 4'd0;
            rsp_tag_q    <= 4'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_hi_q     <= rsp_hi_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_result = rsp_result_q;
    assign rsp_hi     = rsp_hi_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_err    = rsp_err_q;
    assign done_count = done_q;

endmodule

// File: doc/alu32_seq.md
# alu32_seq

Command sequencer sitting in front of `alu32`, acting as the hardware initiator for it. It accepts tagged operation requests over a valid/ready command port and drives the ALU operand and opcode inputs. After a fixed latency it captures the result, high product word and NZVC flags, then returns them over a valid/ready response port. Illegal requests are screened out and never reach the ALU.

## Interface
- `LATENCY`, default 1: cycles operands must be held on the ALU before its outputs are sampled; legal range 1..15.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: sequencer can accept a command.
- `cmd_op` input 4: ALU opcode (0000 ADD … 1011 COMP).
- `cmd_a`, `cmd_b` input 32 each: operands.
- `cmd_tag` input 4: request tag, echoed on the response.
- `alu_a`, `alu_b` output 32 each: to ALU `A`/`B`.
- `alu_op` output 4: to ALU `op`.
- `alu_result`, `alu_mul_hi` input 32 each: from ALU `result`/`mul_hi`.
- `alu_n`, `alu_z`, `alu_v`, `alu_c` input 1 each: ALU flags.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_result`, `rsp_hi` output 32 each: captured result and high word.
- `rsp_flags` output 4: {N,Z,V,C}.
- `rsp_tag` output 4: echoed tag.
- `rsp_err` output 1: request was rejected (illegal op or divide by zero).
- `done_count` output 16: number of completed response handshakes.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1.
  - WAIT: operands on ALU, latency counter running.
  - RESP: `rsp_valid`=1.
- IDLE transitions on accept (`cmd_valid && cmd_ready`):
  - op 1100–1111: go to RESP with `rsp_err`=1, result 0, hi 0, flags 0000.
  - op 0011 with `cmd_b`==0: go to RESP with `rsp_err`=1, result 32'hFFFFFFFF, hi 0, flags 0000.
  - Error paths leave `alu_a`/`alu_b`/`alu_op` unchanged.
  - Otherwise: register `cmd_a`/`cmd_b`/`cmd_op` onto `alu_*`, load counter with `LATENCY-1`, go to WAIT.
- WAIT: hold `alu_*` stable. When the counter is 0, capture `alu_result`, `alu_mul_hi` and flags into the `rsp_*` registers with `rsp_err`=0, then go to RESP. Otherwise decrement the counter.
- RESP: hold every `rsp_*` output stable until `rsp_ready`. On the handshake, go to IDLE and increment `done_count`.
- `done_count` wraps from 16'hFFFF to 0. Error responses also count.
- `rsp_tag` is always the tag of the accepted command.
- `alu_*` keep their last value in IDLE/RESP; no re-drive to 0.
- `cmd_ready` is purely (state==IDLE) and forced 0 while `rst` is high. There is no command/response overlap.

## Timing
- Reset (async assert, any state): state=IDLE, counter=0, `done_count`=0, all `alu_*` and `rsp_*` outputs 0, `rsp_valid`=0, `cmd_ready`=0 while held. `cmd_ready`=1 in the first cycle after deassertion.
- Reset mid-WAIT or mid-RESP discards the in-flight command with no response and no count increment.
- Normal op accepted at edge T:
  - `alu_*` valid from T+1.
  - Results sampled at edge T+LATENCY.
  - `rsp_valid` high from T+LATENCY through the handshake edge.
- Error op accepted at T: `rsp_valid` high from T+1.
- Response handshake at edge R: `rsp_valid`=0 and `cmd_ready`=1 after R. The earliest next accept is R+1.
- Peak throughput: one normal command per LATENCY+2 cycles.
- `cmd_*` inputs are ignored outside IDLE. `rsp_ready` is ignored outside RESP.

## Test plan
- LATENCY=1: ADD 10+5, tag 3, `rsp_ready`=1 → `rsp_valid` one cycle after accept, result 15, flags 0000, tag 3, err 0, `done_count`=1.
- LATENCY=3: MUL 32'h10000×32'h10000 → `alu_*` stable for 3 cycles, `rsp_hi`=1, result 0, `rsp_valid` 3 cycles after accept.
- Backpressure: SUB 5−7 with `rsp_ready` low for 5 cycles → `rsp_*` frozen (result 32'hFFFFFFFE, N=1), `cmd_ready`=0, extra `cmd_valid` ignored, `done_count` unchanged until the handshake.
- Errors:
  - DIV 15/0 → response one cycle after accept: result 32'hFFFFFFFF, err 1, `alu_*` unchanged.
  - Op 4'b1110 → result 0, err 1.
- Reset mid-WAIT (LATENCY=4, `rst` asserted 2 cycles after accept) → all outputs 0 immediately, no response, `done_count`=0, `cmd_ready`=1 after release.
- Wrap: 65536 back-to-back error-op handshakes → `done_count` returns to 0.
